// File: rtl/picomips_test_harness_pkg.sv
// Shared constants, run-mode encoding and counter sizing for the picoMIPS board harness.
package picomips_harness_pkg;

    localparam int SW_W_DEF     = 10;
    localparam int LED_W_DEF    = 8;
    localparam int DEBOUNCE_DEF = 65536;

    typedef enum logic {
        RUN_FREE = 1'b0,
        RUN_STEP = 1'b1
    } run_mode_e;

    // Bits needed for a counter that runs 0..n-1. Always at least 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/picomips_test_harness_if.sv
// Bundle between the harness, the board pins and the picoMIPS core.
// The master side drives the board inputs and the core output. The slave side is the harness.
interface picomips_test_harness_if
    import picomips_harness_pkg::*;
#(
    parameter int SW_W  = SW_W_DEF,
    parameter int LED_W = LED_W_DEF
);
    logic [SW_W-1:0]  SW;
    logic             step_btn;
    logic             step_mode;
    logic [LED_W-1:0] core_led;
    logic [SW_W-1:0]  core_sw;
    logic             core_en;
    logic [LED_W-1:0] LED;

    modport master (
        output SW, step_btn, step_mode, core_led,
        input  core_sw, core_en, LED
    );

    modport slave (
        input  SW, step_btn, step_mode, core_led,
        output core_sw, core_en, LED
    );

endinterface

// File: rtl/picomips_test_harness_sw_debounce.sv
// Two-flop synchroniser followed by a per-bit debouncer.
// A bit's clean value only follows the synced input after CYCLES consecutive differing samples.
// accept strobes in the cycle whose clock edge will load the new clean value.
module sw_debounce
    import picomips_harness_pkg::*;
#(
    parameter int W      = 1,
    parameter int CYCLES = DEBOUNCE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] clean,
    output logic [W-1:0] accept
);
    localparam int            CW = cnt_width(CYCLES);
    localparam logic [CW-1:0] TC = CW'(CYCLES - 1);

    logic [W-1:0]  s1, s2;
    logic [CW-1:0] cnt [W];

    // Bring the raw asynchronous inputs into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Flag bits whose change has been stable long enough to be taken.
    always_comb begin
        accept = '0;
        for (int i = 0; i < W; i++) begin
            accept[i] = (s2[i] != clean[i]) && (cnt[i] == TC);
        end
    end

    // Count consecutive differing samples per bit. Accept at terminal count; restart on revert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clean <= '0;
            for (int i = 0; i < W; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                if (s2[i] == clean[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == TC) begin
                    clean[i] <= s2[i];
                    cnt[i]   <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/picomips_test_harness.sv
// Board-level harness around the picoMIPS core: debounced switches, a free-run or
// single-step core clock-enable, and an LED register updated on completed core cycles.
module picomips_test_harness
    import picomips_harness_pkg::*;
#(
    parameter int SW_W            = SW_W_DEF,
    parameter int LED_W           = LED_W_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int CLK_DIV         = 1
) (
    input logic                    fastclk,
    input logic                    reset,
    picomips_test_harness_if.slave bus
);
    localparam int            DW     = cnt_width(CLK_DIV);
    localparam logic [DW-1:0] DIV_TC = DW'(CLK_DIV - 1);

    logic [SW_W-1:0] sw_acc_unused;
    logic [0:0]      btn_clean, btn_acc;
    logic [0:0]      mode_clean, mode_acc;
    run_mode_e       mode;
    logic [DW-1:0]   div;
    logic            rise_q;

    sw_debounce #(.W(SW_W), .CYCLES(DEBOUNCE_CYCLES)) u_sw (
        .clk    (fastclk),
        .rst    (reset),
        .din    (bus.SW),
        .clean  (bus.core_sw),
        .accept (sw_acc_unused)
    );

    sw_debounce #(.W(1), .CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk    (fastclk),
        .rst    (reset),
        .din    (bus.step_btn),
        .clean  (btn_clean),
        .accept (btn_acc)
    );

    sw_debounce #(.W(1), .CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk    (fastclk),
        .rst    (reset),
        .din    (bus.step_mode),
        .clean  (mode_clean),
        .accept (mode_acc)
    );

    assign mode = run_mode_e'(mode_clean[0]);

    // Remember a debounced button press. A press landing with a mode change is dropped.
    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) rise_q <= 1'b0;
        else       rise_q <= btn_acc[0] & ~btn_clean[0] & ~mode_acc[0];
    end

    // Divider and enable: a mode change restarts the divider and blanks the enable for one cycle.
    always_ff @(posedge fastclk or posedge reset) begin
        if (reset) begin
            div         <= '0;
            bus.core_en <= 1'b0;
        end else if (mode_acc[0]) begin
            div         <= '0;
            bus.core_en <= 1'b0;
        end else if (mode == RUN_STEP) begin
            div         <= '0;
            bus.core_en <= rise_q;
        end else begin
            bus.core_en <= (div == DIV_TC);
            div         <= (div == DIV_TC) ? '0 : div + 1'b1;
        end
    end

    // Take the core output only at the end of an enabled core cycle.
    always_ff @(posedge fastclk or posedge reset) begin
        if (reset)            bus.LED <= '0;
        else if (bus.core_en) bus.LED <= bus.core_led;
    end

endmodule

// File: tb/tb_picomips_test_harness.sv
// Directed bench for picomips_test_harness with a cycle-stamped expectation queue.
module tb_picomips_test_harness;
    localparam int SW_W = 10;
    localparam int LED_W = 8;
    localparam int DEB = 4;
    localparam int DIV = 3;

    localparam int S_SW  = 0;
    localparam int S_EN  = 1;
    localparam int S_LED = 2;
    localparam int S_DIV = 3;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    logic fastclk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    exp_t sb[$];

    picomips_test_harness_if #(.SW_W(SW_W), .LED_W(LED_W)) bus ();

    picomips_test_harness #(
        .SW_W(SW_W), .LED_W(LED_W), .DEBOUNCE_CYCLES(DEB), .CLK_DIV(DIV)
    ) dut (
        .fastclk (fastclk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 fastclk = ~fastclk;

    function automatic logic [7:0] fled(input int c);
        return 8'((c * 7 + 3) & 255);
    endfunction

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_SW:    return 32'(bus.core_sw);
            S_EN:    return 32'(bus.core_en);
            S_LED:   return 32'(bus.LED);
            default: return 32'(dut.div);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, o, e, cyc);
        end
    endtask

    task automatic push(input int due, input int sel, input logic [31:0] e, input string tag);
        exp_t x;
        x.due = due;
        x.sel = sel;
        x.exp = e;
        x.tag = tag;
        sb.push_back(x);
    endtask

    // One clock edge, then compare everything due at this edge and advance core_led.
    task automatic tick();
        @(posedge fastclk);
        cyc++;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].tag, obs(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end
        end
        bus.core_led = fled(cyc);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_core_sw"}, 32'(bus.core_sw), 32'd0);
        chk({tag, "_core_en"}, 32'(bus.core_en), 32'd0);
        chk({tag, "_led"}, 32'(bus.LED), 32'd0);
    endtask

    initial begin
        int c0, p, q, guard;
        bus.SW = 10'h3FF;
        bus.step_btn = 1'b0;
        bus.step_mode = 1'b0;
        bus.core_led = 8'h00;

        // Asynchronous reset mid-cycle clears outputs at once.
        ticks(2);
        #3 reset = 1'b1;
        #1 check_zero_outputs("reset_async");
        ticks(2);
        reset = 1'b0;
        c0 = cyc;
        push(c0 + 5, S_SW, 32'h000, "sw_reset_latency_early");
        push(c0 + 6, S_SW, 32'h3FF, "sw_reset_latency");
        push(c0 + 7, S_SW, 32'h3FF, "sw_reset_hold");
        // Free-run: a pulse every third edge, LED capturing core_led from the pulse cycle.
        for (int d = 1; d <= 15; d++) begin
            push(c0 + d, S_EN, 32'((d % DIV) == 0), "freerun_en");
            if (d < 4) push(c0 + d, S_LED, 32'h0, "freerun_led_reset");
            else       push(c0 + d, S_LED, 32'(fled(c0 + DIV * ((d - 1) / DIV))), "freerun_led");
        end
        ticks(16);

        // Clear SW[0] so a high glitch can be tried on it.
        p = cyc;
        bus.SW = 10'h3FE;
        push(p + 5, S_SW, 32'h3FF, "sw0_fall_early");
        push(p + 6, S_SW, 32'h3FE, "sw0_fall");
        ticks(8);

        // Three-cycle high pulse on SW[0] is rejected.
        bus.SW = 10'h3FF;
        ticks(3);
        bus.SW = 10'h3FE;
        for (int d = 1; d <= 10; d++) push(cyc + d, S_SW, 32'h3FE, "glitch_reject");
        ticks(10);

        // Held change is accepted after the full latency.
        p = cyc;
        bus.SW = 10'h3FF;
        push(p + 5, S_SW, 32'h3FE, "sw0_rise_early");
        push(p + 6, S_SW, 32'h3FF, "sw0_rise");
        ticks(8);

        // Enter step mode so that the debounced change lands while div is 1.
        guard = 0;
        while ((((cyc + 5 - c0) % DIV) != 1) && (guard < 10)) begin
            tick();
            guard++;
        end
        q = cyc;
        bus.step_mode = 1'b1;
        push(q + 5, S_DIV, 32'd1, "mode_step_div_before");
        for (int d = 6; d <= 9; d++) begin
            push(q + d, S_EN, 32'd0, "mode_step_en");
            push(q + d, S_DIV, 32'd0, "mode_step_div");
        end
        ticks(10);

        // Three clean presses, one single-cycle pulse each.
        for (int n = 0; n < 3; n++) begin
            p = cyc;
            bus.step_btn = 1'b1;
            for (int d = 1; d <= 20; d++) begin
                push(p + d, S_EN, 32'(d == 7), "step_en");
                push(p + d, S_DIV, 32'd0, "step_div");
            end
            push(p + 8, S_LED, 32'(fled(p + 7)), "step_led");
            ticks(10);
            bus.step_btn = 1'b0;
            ticks(10);
        end

        // Two-cycle bounce on the button gives nothing.
        bus.step_btn = 1'b1;
        for (int d = 1; d <= 12; d++) push(cyc + d, S_EN, 32'd0, "bounce_en");
        ticks(2);
        bus.step_btn = 1'b0;
        ticks(10);

        // Back to free-run: first pulse three edges after the debounced change.
        q = cyc;
        bus.step_mode = 1'b0;
        for (int d = 1; d <= 12; d++) push(q + d, S_EN, 32'(d == 9 || d == 12), "mode_free_en");
        push(q + 6, S_DIV, 32'd0, "mode_free_div");
        push(q + 7, S_DIV, 32'd1, "mode_free_div_next");
        ticks(13);

        // Reset while a SW[5] change is part way through debouncing.
        p = cyc;
        bus.SW = 10'h3DF;
        ticks(4);
        chk("sw5_cnt_before_reset", 32'(dut.u_sw.cnt[5]), 32'd2);
        #3 reset = 1'b1;
        #1 check_zero_outputs("reset_midop");
        ticks(2);
        reset = 1'b0;
        c0 = cyc;
        push(c0 + 5, S_SW, 32'h000, "sw5_after_reset_early");
        push(c0 + 6, S_SW, 32'h3DF, "sw5_after_reset");
        push(c0 + 2, S_EN, 32'd0, "restart_en_early");
        push(c0 + 3, S_EN, 32'd1, "restart_en");
        ticks(8);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
